// File: rtl/sra_pipe.sv
// Pipelined 32-bit right shifter: one register per binary shift stage (16,8,4,2,1),
// arithmetic/logical fill, tag pass-through, bubble-collapsing valid/ready flow control.
module sra_pipe #(
    parameter  int unsigned SHW   = 5,
    parameter  int unsigned TAG_W = 5,
    localparam int unsigned WIDTH = 2 ** SHW
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic [SHW-1:0]   shamt,
    input  logic             arith,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic [TAG_W-1:0] tag_out
);

    // Stage k holds the shamt bits not yet consumed; the last stage needs none,
    // so shamt/fill storage exists only for stages 0..SHW-2.
    logic [SHW-1:0]   r_valid;
    logic [WIDTH-1:0] r_data [SHW];
    logic [TAG_W-1:0] r_tag  [SHW];
    logic [SHW-2:0]   r_sh   [SHW-1];
    logic [SHW-2:0]   r_fill;

    logic [SHW-1:0]   w_adv;
    logic [SHW-1:0]   w_nv;
    logic [WIDTH-1:0] w_nd  [SHW];
    logic [TAG_W-1:0] w_nt  [SHW];
    logic [SHW-2:0]   w_nsh [SHW-1];
    logic [SHW-2:0]   w_nf;
    logic             w_fill_in;

    function automatic logic [WIDTH-1:0] shr(input logic [WIDTH-1:0] d,
                                             input logic             f,
                                             input int unsigned      amt);
        logic [WIDTH-1:0] ones;
        ones = '1;
        return (d >> amt) | (f ? ~(ones >> amt) : '0);
    endfunction

    // A stage advances if it or any stage downstream of it is empty, or the consumer takes the result.
    always_comb begin
        logic go;
        go    = out_ready;
        w_adv = '0;
        for (int unsigned i = 0; i < SHW; i++) begin
            go                = go | ~r_valid[SHW-1-i];
            w_adv[SHW-1-i]    = go;
        end
    end

    assign in_ready  = ~reset & ~flush & w_adv[0];
    assign w_fill_in = arith & data_in[WIDTH-1];

    always_comb begin
        w_nv     = '0;
        w_nf     = '0;
        w_nv[0]  = in_valid & in_ready;
        w_nd[0]  = shamt[SHW-1] ? shr(data_in, w_fill_in, WIDTH / 2) : data_in;
        w_nt[0]  = tag_in;
        w_nsh[0] = shamt[SHW-2:0];
        w_nf[0]  = w_fill_in;
        for (int unsigned k = 1; k < SHW; k++) begin
            w_nv[k] = r_valid[k-1];
            w_nd[k] = r_sh[k-1][SHW-1-k] ? shr(r_data[k-1], r_fill[k-1], 1 << (SHW-1-k))
                                        : r_data[k-1];
            w_nt[k] = r_tag[k-1];
        end
        for (int unsigned k = 1; k < SHW-1; k++) begin
            w_nsh[k] = r_sh[k-1];
            w_nf[k]  = r_fill[k-1];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            r_fill  <= '0;
            for (int unsigned k = 0; k < SHW; k++) begin
                r_data[k] <= '0;
                r_tag[k]  <= '0;
            end
            for (int unsigned k = 0; k < SHW-1; k++) begin
                r_sh[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < SHW; k++) begin
                if (flush) begin
                    r_valid[k] <= 1'b0;
                end else if (w_adv[k]) begin
                    r_valid[k] <= w_nv[k];
                end
                if (w_adv[k]) begin
                    r_data[k] <= w_nd[k];
                    r_tag[k]  <= w_nt[k];
                end
            end
            for (int unsigned k = 0; k < SHW-1; k++) begin
                if (w_adv[k]) begin
                    r_sh[k]   <= w_nsh[k];
                    r_fill[k] <= w_nf[k];
                end
            end
        end
    end

    assign out_valid = r_valid[SHW-1];
    assign data_out  = r_data[SHW-1];
    assign tag_out   = r_tag[SHW-1];

endmodule

// File: doc/sra_pipe.md
Name: sra_pipe

Overview:
- Pipelined 32-bit right shifter feeding the ALU/writeback path; replaces the single-cycle combinational sra chain where timing demands it.
- Built from the per-bit right-shift stages (16, 8, 4, 2, 1), with a register after every stage.
- Supports arithmetic (sign-fill) and logical (zero-fill) shifts.
- Valid/ready handshake on both sides; carries an opaque tag (destination register) alongside the data.

Parameters:
- SHW, 5, shift-amount width; data width WIDTH = 2**SHW (32); pipeline depth = SHW stages.
- TAG_W, 5, width of the pass-through tag.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous kill of all in-flight operations
- in_valid  in  1  input operation present
- in_ready  out  1  block accepts an input this cycle
- data_in  in  WIDTH  operand
- shamt  in  SHW  shift amount, 0..WIDTH-1
- arith  in  1  1 = sign-fill, 0 = zero-fill
- tag_in  in  TAG_W  opaque tag
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- data_out  out  WIDTH  shifted result
- tag_out  out  TAG_W  tag of the result

Behaviour:
- Stages k = 0..SHW-1. Stage k shifts right by 2**(SHW-1-k) when shamt bit (SHW-1-k) is set, otherwise passes the value through. Stage 0 shifts by 16; the last stage shifts by 1.
- Fill bit = arith & data_in[WIDTH-1], captured at acceptance. It travels with the operation, along with the remaining shamt bits, arith, and tag.
- Each stage register holds: valid, data, remaining shamt bits, fill, tag.
- Acceptance: in_valid & in_ready at a rising edge.
- Latency: a result accepted at edge N appears on out_valid/data_out after edge N+SHW-1 (SHW register stages, last register drives outputs). With no stalls, throughput is one operation per cycle.
- Last stage outputs drive out_valid, data_out, and tag_out directly from registers.
- Bubble-collapsing backpressure: stage k advances iff it is empty, or stage k+1 advances. The last stage advances iff out_valid = 0 or out_ready = 1.
- in_ready = ~reset & ~flush & (stage 0 empty | stage 0 advances). It is combinational, with no combinational path from in_valid.
- A stalled stage holds all of its fields unchanged. Operations never reorder, drop, or duplicate.
- out_valid, data_out, and tag_out are stable while out_valid = 1 and out_ready = 0.
- shamt = 0: data_out = data_in unchanged (both modes).
- flush = 1 at an edge: all stage valids clear. An input presented in the same cycle is not accepted, and out_valid is 0 the next cycle. A result handshaking (out_valid & out_ready) in the flush cycle counts as delivered.
- reset asserted at any time, including mid-operation: all valids, data, and tags clear to 0 immediately. out_valid = 0, data_out = 0, tag_out = 0, in_ready = 0.
- After reset deasserts, in_ready = 1 in the first cycle.
- No arithmetic beyond shifting. Bits shifted out are discarded, with no sticky/overflow flag.

Test Plan:
- Arith 0x80000000, shamt 2, tag 3, out_ready held 1: out_valid after 5 edges, data_out 0xE0000000, tag_out 3.
- Logical 0x80000000 shamt 31 -> 0x00000001. Arith 0xF0000000 shamt 31 -> 0xFFFFFFFF. Arith 0x7FFFFFFF shamt 4 -> 0x07FFFFFF. shamt 0 -> unchanged.
- Back-to-back: 8 consecutive inputs with in_valid held 1 and out_ready 1. Expect 8 results on 8 consecutive cycles, in order, tags 0..7.
- Backpressure: fill the pipe with 5 ops, then drop out_ready for 3 cycles.
  - in_ready = 0 and data_out/tag_out stay stable.
  - After release, all 5 results emerge in order with no loss.
  - Also insert a bubble upstream mid-pipe and check it collapses.
- Flush: 3 ops in flight plus in_valid = 1 in the flush cycle. Next cycle out_valid = 0, and no flushed or rejected op ever emerges. A new op issued afterwards returns correctly after 5 edges.
- Reset mid-operation: assert reset asynchronously between edges with 4 ops in flight.
  - Outputs go to 0 and in_ready to 0 immediately.
  - After deassert, in_ready = 1 and no stale result appears.
